// File: rtl/cla_ctrl_pkg.sv
// Shared definitions for the byte-serial CLA add/subtract controller.
//   BYTE_W   : width of one adder slice
//   OPCNT_W  : width of the optional completed-operation counter
//   state_e  : controller FSM encoding
//   idx_w()  : byte-index width helper (never narrower than one bit)
package cla_ctrl_pkg;

    localparam int BYTE_W  = 8;
    localparam int OPCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a counter addressing n slices; one bit minimum so n=1 still works.
    function automatic int idx_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/cla_serial_add_ctrl_cla8.sv
// CLA_8bit: 8-bit carry-lookahead adder slice.
// Ports:
//   S    : 8-bit sum
//   G, P : group generate / group propagate of the slice
//   Cout : carry out of bit 7
//   A, B : 8-bit addends
//   Cin  : carry in to bit 0
module CLA_8bit (
    output logic [7:0] S,
    output logic       G,
    output logic       P,
    output logic       Cout,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin
);

    logic [7:0] gen_s;
    logic [7:0] prop_s;
    logic [8:0] carry_s;
    logic       term_s;
    logic       grp_term_s;

    // Per-bit generate/propagate and lookahead carries; each carry is built
    // from the bit terms and Cin only, never from a neighbouring carry.
    always_comb begin
        gen_s      = A & B;
        prop_s     = A ^ B;
        carry_s    = 9'd0;
        term_s     = 1'b0;
        grp_term_s = 1'b0;
        carry_s[0] = Cin;
        for (int i = 0; i < 8; i++) begin
            term_s = Cin;
            for (int j = 0; j <= i; j++) begin
                term_s = gen_s[j] | (prop_s[j] & term_s);
            end
            carry_s[i+1] = term_s;
        end
        for (int j = 0; j < 8; j++) begin
            grp_term_s = gen_s[j] | (prop_s[j] & grp_term_s);
        end
        S    = prop_s ^ carry_s[7:0];
        G    = grp_term_s;
        P    = &prop_s;
        Cout = carry_s[8];
    end

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// cla_serial_add_ctrl: byte-serial multi-precision add/subtract controller.
// One CLA_8bit slice processes the operands LSB byte first; the carry is
// chained through a register between cycles.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   start_valid/start_ready  : operation handshake (ready only in IDLE)
//   a, b, cin, op_sub        : operands, carry-in (ignored for subtract), op
//   res_valid/res_ready      : result handshake (valid only in DONE)
//   sum, cout, ovf           : result, carry out (1 = no borrow), signed overflow
//   op_count                 : completed result handshakes, saturating
//                              (present only when CLA_SERIAL_OPCNT_EN is defined)
// Optional build macro: CLA_SERIAL_OPCNT_EN
module cla_serial_add_ctrl
    import cla_ctrl_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [8*NUM_BYTES-1:0]   a,
    input  logic [8*NUM_BYTES-1:0]   b,
    input  logic                     cin,
    input  logic                     op_sub,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [8*NUM_BYTES-1:0]   sum,
    output logic                     cout,
    output logic                     ovf
`ifdef CLA_SERIAL_OPCNT_EN
    ,
    output logic [OPCNT_W-1:0]       op_count
`endif
);

    localparam int WIDTH = BYTE_W * NUM_BYTES;
    localparam int IDX_W = idx_w(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_e              state_r;
    state_e              state_nx_s;
    logic [IDX_W-1:0]    idx_r;
    logic                carry_r;
    logic [WIDTH-1:0]    opa_r;
    logic [WIDTH-1:0]    opb_r;
    logic [WIDTH-1:0]    sum_r;
    logic                cout_r;
    logic                ovf_r;
    logic                start_ready_r;
    logic                res_valid_r;

    logic [BYTE_W-1:0]   byte_a_s;
    logic [BYTE_W-1:0]   byte_b_s;
    logic [BYTE_W-1:0]   byte_sum_s;
    logic                byte_cout_s;
    logic                accept_s;
    logic                drain_s;
    logic                last_s;

    assign accept_s = start_valid && start_ready_r;
    assign drain_s  = res_valid_r && res_ready;
    assign last_s   = (idx_r == LAST_IDX);

    // Select the operand byte addressed by the current slice index.
    always_comb begin
        byte_a_s = opa_r[idx_r*BYTE_W +: BYTE_W];
        byte_b_s = opb_r[idx_r*BYTE_W +: BYTE_W];
    end

    CLA_8bit u_cla (
        .S    (byte_sum_s),
        .G    (),
        .P    (),
        .Cout (byte_cout_s),
        .A    (byte_a_s),
        .B    (byte_b_s),
        .Cin  (carry_r)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (drain_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they line up
    // with the state they describe and stay low while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_ready_r <= 1'b0;
            res_valid_r   <= 1'b0;
        end else begin
            start_ready_r <= (state_nx_s == IDLE);
            res_valid_r   <= (state_nx_s == DONE);
        end
    end

    // Operand capture, per-byte accumulation and final flag update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_r   <= '0;
            opb_r   <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        // Subtract is A + ~B + 1, so the inversion happens once here.
                        opa_r   <= a;
                        opb_r   <= op_sub ? ~b : b;
                        carry_r <= op_sub ? 1'b1 : cin;
                        idx_r   <= '0;
                        sum_r   <= '0;
                    end
                end
                RUN: begin
                    sum_r[idx_r*BYTE_W +: BYTE_W] <= byte_sum_s;
                    carry_r <= byte_cout_s;
                    if (last_s) begin
                        // Index parks on the top slice instead of wrapping.
                        cout_r <= byte_cout_s;
                        ovf_r  <= (opa_r[WIDTH-1] == opb_r[WIDTH-1]) &&
                                  (byte_sum_s[BYTE_W-1] != opa_r[WIDTH-1]);
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    // Result held until the consumer takes it.
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

`ifdef CLA_SERIAL_OPCNT_EN
    logic [OPCNT_W-1:0] op_count_r;

    // Saturating count of completed result handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_r <= '0;
        end else if (drain_s && (op_count_r != {OPCNT_W{1'b1}})) begin
            op_count_r <= op_count_r + OPCNT_W'(1);
        end
    end

    assign op_count = op_count_r;
`endif

    assign start_ready = start_ready_r;
    assign res_valid   = res_valid_r;
    assign sum         = sum_r;
    assign cout        = cout_r;
    assign ovf         = ovf_r;

endmodule
